lamp_output_driver: RTL and testbench



---
 rtl/lamp_output_driver.sv | 166 ++++++++++++++++
 tb/tb_lamp_output_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_output_driver.sv
// rtl/lamp_output_driver.sv - lamp LED driver with break-before-make blanking, PWM dimming and red-flash fault mode
module lamp_output_driver #(
   parameter int PWM_BITS          = 8,
   parameter int BLANK_CYCLES      = 100_000,
   parameter int FAULT_CYCLES      = 1_000_000,
   parameter int FLASH_HALF_CYCLES = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                red_in,
   input  logic                blue_in,
   input  logic                green_in,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                fault_clear,
   output logic                red_led,
   output logic                blue_led,
   output logic                green_led,
   output logic                fault,
   output logic [1:0]          active_lamp
);

   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int FW = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;
   localparam int HW = (FLASH_HALF_CYCLES > 1) ? $clog2(FLASH_HALF_CYCLES) : 1;

   typedef enum logic [1:0] {S_WAIT, S_BLANK, S_ON, S_FAULT} state_t;

   state_t              state;
   logic [2:0]          req_q;
   logic [1:0]          target;
   logic [BW-1:0]       blank_cnt;
   logic [FW-1:0]       fault_cnt;
   logic [HW-1:0]       flash_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty;
   logic [2:0]          leds;
   logic                fault_q;
   logic [1:0]          active_q;

   logic                req_valid;
   logic [1:0]          req_lamp;
   logic [1:0]          blank_tgt;
   logic [PWM_BITS-1:0] pwm_cnt_n;
   logic [PWM_BITS-1:0] duty_n;
   logic                gate_n;
   logic                enter_fault;

   always_comb begin
      req_valid = 1'b0;
      req_lamp  = 2'd0;
      case (req_q)
         3'b100: begin req_valid = 1'b1; req_lamp = 2'd1; end
         3'b010: begin req_valid = 1'b1; req_lamp = 2'd2; end
         3'b001: begin req_valid = 1'b1; req_lamp = 2'd3; end
         default: ;
      endcase
   end

   // LED registers are loaded with the gate of the cycle they will be visible in
   always_comb begin
      pwm_cnt_n   = pwm_cnt + 1'b1;
      duty_n      = (pwm_cnt == '0) ? brightness : duty;
      gate_n      = (&duty_n) || (pwm_cnt_n < duty_n);
      blank_tgt   = req_valid ? req_lamp : target;
      enter_fault = !req_valid && (fault_cnt == FW'(FAULT_CYCLES - 1));
   end

   function automatic logic [2:0] lamp_mask(input logic [1:0] code, input logic g);
      case (code)
         2'd1:    return {g, 2'b00};
         2'd2:    return {1'b0, g, 1'b0};
         2'd3:    return {2'b00, g};
         default: return 3'b000;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_WAIT;
         req_q     <= 3'b000;
         target    <= 2'd0;
         blank_cnt <= '0;
         fault_cnt <= '0;
         flash_cnt <= '0;
         pwm_cnt   <= '0;
         duty      <= '0;
         leds      <= 3'b000;
         fault_q   <= 1'b0;
         active_q  <= 2'd0;
      end else begin
         req_q   <= {red_in, blue_in, green_in};
         pwm_cnt <= pwm_cnt_n;
         duty    <= duty_n;
         if (state != S_FAULT)
            fault_cnt <= req_valid ? '0 : fault_cnt + 1'b1;

         if (state != S_FAULT && enter_fault) begin
            state     <= S_FAULT;
            fault_cnt <= '0;
            flash_cnt <= '0;
            leds      <= 3'b100;
            fault_q   <= 1'b1;
            active_q  <= 2'd0;
         end else begin
            case (state)
               S_WAIT: begin
                  leds     <= 3'b000;
                  active_q <= 2'd0;
                  if (req_valid) begin
                     state     <= S_BLANK;
                     target    <= req_lamp;
                     blank_cnt <= BW'(BLANK_CYCLES - 1);
                  end
               end
               S_BLANK: begin
                  target <= blank_tgt;
                  if (blank_cnt == '0) begin
                     state    <= S_ON;
                     leds     <= lamp_mask(blank_tgt, gate_n);
                     active_q <= blank_tgt;
                  end else begin
                     blank_cnt <= blank_cnt - 1'b1;
                     leds      <= 3'b000;
                     active_q  <= 2'd0;
                  end
               end
               S_ON: begin
                  if (req_valid && req_lamp != target) begin
                     state     <= S_BLANK;
                     target    <= req_lamp;
                     blank_cnt <= BW'(BLANK_CYCLES - 1);
                     leds      <= 3'b000;
                     active_q  <= 2'd0;
                  end else begin
                     leds     <= lamp_mask(target, gate_n);
                     active_q <= target;
                  end
               end
               S_FAULT: begin
                  if (fault_clear && req_valid) begin
                     state     <= S_BLANK;
                     target    <= req_lamp;
                     blank_cnt <= BW'(BLANK_CYCLES - 1);
                     fault_cnt <= '0;
                     leds      <= 3'b000;
                     fault_q   <= 1'b0;
                  end else if (flash_cnt == HW'(FLASH_HALF_CYCLES - 1)) begin
                     flash_cnt <= '0;
                     leds      <= {~leds[2], 2'b00};
                  end else begin
                     flash_cnt <= flash_cnt + 1'b1;
                  end
               end
               default: state <= S_WAIT;
            endcase
         end
      end
   end

   assign red_led     = leds[2];
   assign blue_led    = leds[1];
   assign green_led   = leds[0];
   assign fault       = fault_q;
   assign active_lamp = active_q;

endmodule

// File: tb/tb_lamp_output_driver.sv
// tb/tb_lamp_output_driver.sv - scoreboard bench for lamp_output_driver
module tb_lamp_output_driver;

   localparam int BC = 4;
   localparam int FC = 8;
   localparam int FH = 6;
   localparam int M_WAIT = 0, M_BLANK = 1, M_ON = 2, M_FAULT = 3;

   logic       clk = 1'b0;
   logic       rst, red_in, blue_in, green_in, fault_clear;
   logic [3:0] brightness;
   logic       red_led, blue_led, green_led, fault;
   logic [1:0] active_lamp;

   lamp_output_driver #(
      .PWM_BITS(4), .BLANK_CYCLES(BC), .FAULT_CYCLES(FC), .FLASH_HALF_CYCLES(FH)
   ) dut (
      .clk(clk), .rst(rst), .red_in(red_in), .blue_in(blue_in), .green_in(green_in),
      .brightness(brightness), .fault_clear(fault_clear), .red_led(red_led),
      .blue_led(blue_led), .green_led(green_led), .fault(fault), .active_lamp(active_lamp)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail = 0;
   string      phase = "reset";
   logic [5:0] exp_q[$];

   // reference model state, describing the DUT as it will be after the coming edge
   int         m_st, m_bl, m_inv, m_fl;
   logic [2:0] m_req;
   logic [1:0] m_tgt;
   logic [3:0] m_pwm, m_duty;
   logic       m_flon;
   logic [5:0] m_out;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [1:0] code;
      logic       v, g;
      logic [3:0] pwm_n, duty_n;
      if (rst) begin
         m_st = M_WAIT; m_bl = 0; m_inv = 0; m_fl = 0; m_req = 3'b000; m_tgt = 2'd0;
         m_pwm = 4'd0; m_duty = 4'd0; m_flon = 1'b0; m_out = 6'd0;
         return;
      end
      code = (m_req == 3'b100) ? 2'd1 : (m_req == 3'b010) ? 2'd2 : (m_req == 3'b001) ? 2'd3 : 2'd0;
      v = (code != 2'd0);
      pwm_n  = m_pwm + 4'd1;
      duty_n = (m_pwm == 4'd0) ? brightness : m_duty;
      g = (duty_n == 4'hF) || (pwm_n < duty_n);
      if (m_st != M_FAULT && !v && m_inv == FC - 1) begin
         m_st = M_FAULT; m_inv = 0; m_fl = 0; m_flon = 1'b1;
      end else begin
         if (m_st != M_FAULT) m_inv = v ? 0 : m_inv + 1;
         case (m_st)
            M_WAIT:  if (v) begin m_st = M_BLANK; m_tgt = code; m_bl = BC - 1; end
            M_BLANK: begin
               if (v) m_tgt = code;
               if (m_bl == 0) m_st = M_ON;
               else m_bl--;
            end
            M_ON:    if (v && code != m_tgt) begin m_st = M_BLANK; m_tgt = code; m_bl = BC - 1; end
            default: begin
               if (fault_clear && v) begin
                  m_st = M_BLANK; m_tgt = code; m_bl = BC - 1; m_inv = 0;
               end else if (m_fl == FH - 1) begin
                  m_fl = 0; m_flon = !m_flon;
               end else m_fl++;
            end
         endcase
      end
      m_req = {red_in, blue_in, green_in};
      m_pwm = pwm_n;
      m_duty = duty_n;
      m_out = 6'd0;
      if (m_st == M_ON) begin
         m_out[1:0] = m_tgt;
         if (m_tgt == 2'd1) m_out[5] = g;
         if (m_tgt == 2'd2) m_out[4] = g;
         if (m_tgt == 2'd3) m_out[3] = g;
      end else if (m_st == M_FAULT) begin
         m_out[5] = m_flon;
         m_out[2] = 1'b1;
      end
   endtask

   task automatic step();
      logic [5:0] e;
      model_step();
      exp_q.push_back(m_out);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_eq(phase, {2'b00, red_led, blue_led, green_led, fault, active_lamp}, {2'b00, e});
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_req(input logic r, input logic b, input logic g);
      red_in = r; blue_in = b; green_in = g;
   endtask

   initial begin
      int ons;
      rst = 1'b1; fault_clear = 1'b0; brightness = 4'hF;
      set_req(0, 0, 0);
      steps(2);
      check_eq("reset_outs", {2'b00, red_led, blue_led, green_led, fault, active_lamp}, 8'h00);

      phase = "red_first"; rst = 1'b0; set_req(1, 0, 0);
      steps(5);
      check_eq("red_dark_c5", {7'd0, red_led}, 8'd0);
      step();
      check_eq("red_lit_c6", {5'd0, red_led, active_lamp}, 8'b101);
      steps(3);

      phase = "to_green"; set_req(0, 0, 1);
      steps(2);
      check_eq("red_drop_n2", {7'd0, red_led}, 8'd0);
      steps(3);
      check_eq("green_dark_n5", {7'd0, green_led}, 8'd0);
      step();
      check_eq("green_lit_n6", {5'd0, green_led, active_lamp}, 8'b111);

      phase = "back_red"; set_req(1, 0, 0);
      steps(8);

      phase = "invalid7"; set_req(1, 1, 1);
      steps(7);
      phase = "after7"; set_req(1, 0, 0);
      steps(10);
      check_eq("no_fault_7", {6'd0, fault, red_led}, 8'b01);

      phase = "invalid8"; set_req(1, 1, 1);
      steps(8);
      phase = "fault_entry"; set_req(0, 0, 0);
      step();
      check_eq("fault_on", {5'd0, fault, active_lamp}, 8'b100);
      ons = int'(red_led);
      for (int i = 0; i < 11; i++) begin step(); ons += int'(red_led); end
      check_eq("flash_duty", 8'(ons), 8'd6);
      steps(7);

      phase = "clear_ignored"; fault_clear = 1'b1;
      step();
      fault_clear = 1'b0;
      check_eq("clear_invalid", {7'd0, fault}, 8'd1);
      steps(3);

      phase = "clear_blue"; set_req(0, 1, 0);
      step();
      fault_clear = 1'b1;
      step();
      fault_clear = 1'b0;
      check_eq("clear_valid", {7'd0, fault}, 8'd0);
      steps(3);
      check_eq("blue_blank", {7'd0, blue_led}, 8'd0);
      step();
      check_eq("blue_lit", {5'd0, blue_led, active_lamp}, 8'b110);

      phase = "pwm4"; set_req(1, 0, 0);
      steps(6);
      check_eq("red_relit", {5'd0, red_led, active_lamp}, 8'b101);
      brightness = 4'd4;
      steps(20);
      ons = 0;
      for (int i = 0; i < 16; i++) begin step(); ons += int'(red_led); end
      check_eq("duty4", 8'(ons), 8'd4);

      phase = "pwm8";
      for (int i = 0; i < 20 && m_pwm != 4'd5; i++) step();
      check_eq("pwm_align", {4'd0, m_pwm}, 8'd5);
      brightness = 4'd8;
      ons = 0;
      for (int i = 0; i < 10; i++) begin step(); ons += int'(red_led); end
      check_eq("midperiod_hold", 8'(ons), 8'd0);
      ons = 0;
      for (int i = 0; i < 16; i++) begin step(); ons += int'(red_led); end
      check_eq("duty8", 8'(ons), 8'd8);

      phase = "pwm0"; brightness = 4'd0;
      steps(20);
      ons = 0;
      for (int i = 0; i < 16; i++) begin step(); ons += int'(red_led); end
      check_eq("duty0", 8'(ons), 8'd0);
      check_eq("duty0_active", {6'd0, active_lamp}, 8'd1);

      phase = "rst_blank"; brightness = 4'hF; set_req(0, 0, 1);
      steps(3);
      rst = 1'b1;
      step();
      check_eq("rst_blank_outs", {2'b00, red_led, blue_led, green_led, fault, active_lamp}, 8'h00);
      rst = 1'b0;
      steps(5);
      check_eq("rst_blank_dark", {7'd0, green_led}, 8'd0);
      step();
      check_eq("rst_blank_relit", {5'd0, green_led, active_lamp}, 8'b111);

      phase = "rst_fault"; set_req(0, 0, 0);
      steps(10);
      check_eq("fault_again", {7'd0, fault}, 8'd1);
      rst = 1'b1;
      step();
      check_eq("rst_fault_outs", {2'b00, red_led, blue_led, green_led, fault, active_lamp}, 8'h00);
      rst = 1'b0; set_req(1, 0, 0);
      steps(5);
      check_eq("rst_fault_dark", {7'd0, red_led}, 8'd0);
      step();
      check_eq("rst_fault_relit", {5'd0, red_led, active_lamp}, 8'b101);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
